// File: rtl/or_gate_pkg.sv
// Shared limits and tree-shape helpers for the or_gate reduction tree.
// Optional sticky accumulator is enabled with OR_GATE_STICKY_EN.
package or_gate_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    function automatic int tree_depth(input int width);
        int d;
        d = 0;
        while ((1 << d) < width) d++;
        return d;
    endfunction

    // nodes at a level: each level halves the previous, rounding up
    function automatic int level_count(input int width, input int level);
        return (width + (1 << level) - 1) >> level;
    endfunction

    function automatic int level_offset(input int width, input int level);
        int off;
        off = 0;
        for (int j = 0; j < level; j++) off += level_count(width, j);
        return off;
    endfunction

endpackage

// File: rtl/or_gate_if.sv
// Operand/result bundle between an or_gate and its user.
// sticky and sticky_clr exist only when OR_GATE_STICKY_EN is defined.
interface or_gate_if
    import or_gate_pkg::*;
#(
    parameter int WIDTH = 3
);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_comb;
    logic             out_valid;
    logic             out_q;
`ifdef OR_GATE_STICKY_EN
    logic             sticky;
    logic             sticky_clr;

    modport master (
        output in_valid, in_data, sticky_clr,
        input  out_comb, out_valid, out_q, sticky
    );

    modport slave (
        input  in_valid, in_data, sticky_clr,
        output out_comb, out_valid, out_q, sticky
    );
`else
    modport master (
        output in_valid, in_data,
        input  out_comb, out_valid, out_q
    );

    modport slave (
        input  in_valid, in_data,
        output out_comb, out_valid, out_q
    );
`endif

endinterface

// File: rtl/or_gate_or2_cell.sv
// Two-input OR node of the reduction tree, optionally registered.
// The register only loads when en marks the node's operands as valid.
module or2_cell #(
    parameter bit REG = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic y
);

    if (REG) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y <= 1'b0;
            end else if (en) begin
                y <= a | b;
            end
        end
    end else begin : g_comb
        logic unused_ok;
        assign unused_ok = clk ^ rst_n ^ en;
        assign y = a | b;
    end

endmodule

// File: rtl/or_gate.sv
// OR-reduction built as a balanced tree of or2_cell, flat or pipelined.
// Define OR_GATE_STICKY_EN to add the sticky result accumulator.
module or_gate
    import or_gate_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int PIPELINE = 0
) (
    input logic      clk,
    input logic      rst_n,
    or_gate_if.slave bus
);

    localparam int D          = tree_depth(WIDTH);
    localparam int NODES      = level_offset(WIDTH, D + 1);
    localparam bit REG_LEVELS = (PIPELINE != 0);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("or_gate: WIDTH out of range");
    end

    logic [NODES-1:0] node;
    logic [D:0]       stage_valid;
    logic             q;
    logic             valid;

    assign node[WIDTH-1:0] = bus.in_data;
    assign bus.out_comb    = |bus.in_data;

    for (genvar k = 1; k <= D; k++) begin : g_level
        localparam int PREV_N   = level_count(WIDTH, k - 1);
        localparam int CUR_N    = level_count(WIDTH, k);
        localparam int PREV_OFF = level_offset(WIDTH, k - 1);
        localparam int CUR_OFF  = level_offset(WIDTH, k);

        for (genvar i = 0; i < CUR_N; i++) begin : g_node
            if (2 * i + 1 < PREV_N) begin : g_pair
                or2_cell #(.REG(REG_LEVELS)) u_cell (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (stage_valid[k-1]),
                    .a     (node[PREV_OFF+2*i]),
                    .b     (node[PREV_OFF+2*i+1]),
                    .y     (node[CUR_OFF+i])
                );
            end else begin : g_pass
                // odd leftover keeps level timing via a zero partner
                or2_cell #(.REG(REG_LEVELS)) u_cell (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (stage_valid[k-1]),
                    .a     (node[PREV_OFF+2*i]),
                    .b     (1'b0),
                    .y     (node[CUR_OFF+i])
                );
            end
        end
    end

    if (REG_LEVELS) begin : g_pipe
        logic [D-1:0] vreg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vreg <= '0;
            end else begin
                vreg <= stage_valid[D-1:0];
            end
        end

        assign stage_valid = {vreg, bus.in_valid};
        assign q           = node[NODES-1];
        assign valid       = stage_valid[D];
    end else begin : g_flat
        logic q_r;
        logic valid_r;

        assign stage_valid = {(D + 1){bus.in_valid}};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_r     <= 1'b0;
                valid_r <= 1'b0;
            end else begin
                valid_r <= stage_valid[D];
                if (stage_valid[D]) begin
                    q_r <= node[NODES-1];
                end
            end
        end

        assign q     = q_r;
        assign valid = valid_r;
    end

    assign bus.out_q     = q;
    assign bus.out_valid = valid;

`ifdef OR_GATE_STICKY_EN
    logic sticky_r;

    // a set event beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
        end else if (valid && q) begin
            sticky_r <= 1'b1;
        end else if (bus.sticky_clr) begin
            sticky_r <= 1'b0;
        end
    end

    assign bus.sticky = sticky_r;
`endif

endmodule

// File: tb/tb_or_gate.sv
// Random and directed checks of four or_gate configurations against
// a delay-and-hold reference model; sticky checked with OR_GATE_STICKY_EN.
module tb_or_gate;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    or_gate_if #(.WIDTH(3))  bus0 ();
    or_gate_if #(.WIDTH(3))  bus1 ();
    or_gate_if #(.WIDTH(64)) bus2 ();
    or_gate_if #(.WIDTH(5))  bus3 ();

    or_gate #(.WIDTH(3),  .PIPELINE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    or_gate #(.WIDTH(3),  .PIPELINE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    or_gate #(.WIDTH(64), .PIPELINE(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    or_gate #(.WIDTH(5),  .PIPELINE(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    int checks = 0;
    int errors = 0;

    int          wid [N];
    int          lat [N];
    bit          drv_v [N];
    logic [63:0] drv_d [N];
    bit          drv_c [N];

    logic act_c [N];
    logic act_v [N];
    logic act_q [N];
    logic act_s [N];

    assign act_c[0] = bus0.out_comb;
    assign act_c[1] = bus1.out_comb;
    assign act_c[2] = bus2.out_comb;
    assign act_c[3] = bus3.out_comb;
    assign act_v[0] = bus0.out_valid;
    assign act_v[1] = bus1.out_valid;
    assign act_v[2] = bus2.out_valid;
    assign act_v[3] = bus3.out_valid;
    assign act_q[0] = bus0.out_q;
    assign act_q[1] = bus1.out_q;
    assign act_q[2] = bus2.out_q;
    assign act_q[3] = bus3.out_q;
`ifdef OR_GATE_STICKY_EN
    assign act_s[0] = bus0.sticky;
    assign act_s[1] = bus1.sticky;
    assign act_s[2] = bus2.sticky;
    assign act_s[3] = bus3.sticky;
`else
    assign act_s[0] = 1'b0;
    assign act_s[1] = 1'b0;
    assign act_s[2] = 1'b0;
    assign act_s[3] = 1'b0;
`endif

    // reference: output = input delayed by latency, result held on bubbles
    int          e;
    bit          hv [N][8192];
    logic [63:0] hd [N][8192];
    bit          ev [N];
    bit          eq [N];
    bit          es [N];

    function automatic logic [63:0] mask_of(input int w);
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        bus0.in_valid = drv_v[0];
        bus0.in_data  = drv_d[0][2:0];
        bus1.in_valid = drv_v[1];
        bus1.in_data  = drv_d[1][2:0];
        bus2.in_valid = drv_v[2];
        bus2.in_data  = drv_d[2];
        bus3.in_valid = drv_v[3];
        bus3.in_data  = drv_d[3][4:0];
`ifdef OR_GATE_STICKY_EN
        bus0.sticky_clr = drv_c[0];
        bus1.sticky_clr = drv_c[1];
        bus2.sticky_clr = drv_c[2];
        bus3.sticky_clr = drv_c[3];
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            ev[i] = 1'b0;
            eq[i] = 1'b0;
            es[i] = 1'b0;
            for (int j = 0; j <= e; j++) hv[i][j] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int src;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                hv[i][e] = 1'b0;
            end else begin
                hv[i][e] = drv_v[i];
                hd[i][e] = drv_d[i] & mask_of(wid[i]);
                if (ev[i] && eq[i]) es[i] = 1'b1;
                else if (drv_c[i]) es[i] = 1'b0;
                src = e - lat[i] + 1;
                ev[i] = 1'b0;
                if (src >= 0) begin
                    ev[i] = hv[i][src];
                    if (ev[i]) eq[i] = (hd[i][src] != 64'd0);
                end
            end
        end
        e++;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_u%0d_valid", tag, i), act_v[i], ev[i]);
            check($sformatf("%s_u%0d_q", tag, i), act_q[i], eq[i]);
`ifdef OR_GATE_STICKY_EN
            check($sformatf("%s_u%0d_sticky", tag, i), act_s[i], es[i]);
`endif
        end
    endtask

    task automatic step(input string tag);
        apply();
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("%s_u%0d_comb", tag, i), act_c[i],
                  (drv_d[i] & mask_of(wid[i])) != 64'd0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic set_all(input bit v, input logic [63:0] d, input bit c);
        for (int i = 0; i < N; i++) begin
            drv_v[i] = v;
            drv_d[i] = d;
            drv_c[i] = c;
        end
    endtask

    task automatic idle(input int n);
        set_all(1'b0, 64'd0, 1'b0);
        repeat (n) step("idle");
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs(tag);
        step(tag);
        step(tag);
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rand_word();
        logic [63:0] w;
        case ($urandom_range(0, 3))
            0: w = 64'd0;
            1: w = 64'd1 << $urandom_range(0, 63);
            default: w = {$urandom, $urandom};
        endcase
        return w;
    endfunction

    logic [2:0] seq_d [4];
    logic [2:0] bub_d [3];
    bit         bub_v [3];

    initial begin
        wid = '{3, 3, 64, 5};
        lat = '{1, 2, 6, 3};
        seq_d = '{3'b000, 3'b100, 3'b000, 3'b001};
        bub_d = '{3'b010, 3'b111, 3'b000};
        bub_v = '{1'b1, 1'b0, 1'b1};
        e = 0;
        rst_n = 1'b0;
        set_all(1'b0, 64'd0, 1'b0);
        apply();
        model_reset();
        #3;
        check_outputs("reset");
        @(negedge clk);
        step("reset");
        step("reset");
        rst_n = 1'b1;

        for (int d = 0; d < 8; d++) begin
            set_all(1'b1, 64'(d), 1'b0);
            drv_d[2] = rand_word();
            step("exh");
        end
        idle(8);

        foreach (seq_d[k]) begin
            set_all(1'b1, 64'(seq_d[k]), 1'b0);
            step("seq");
        end
        idle(8);

        foreach (bub_d[k]) begin
            set_all(bub_v[k], 64'(bub_d[k]), 1'b0);
            step("bubble");
        end
        idle(8);

        set_all(1'b1, 64'd0, 1'b0);
        drv_d[2] = 64'd1 << 63;
        drv_d[3] = 64'd1 << 4;
        step("width");
        set_all(1'b1, 64'd0, 1'b0);
        step("width");
        idle(8);

        set_all(1'b1, '1, 1'b0);
        step("flight");
        step("flight");
        async_reset("midrst");
        idle(8);
        set_all(1'b1, 64'd1, 1'b0);
        step("post");
        idle(8);

        set_all(1'b1, 64'd0, 1'b0);
        step("stk");
        set_all(1'b1, 64'd2, 1'b0);
        step("stk");
        set_all(1'b1, 64'd0, 1'b0);
        step("stk");
        idle(8);
        set_all(1'b1, '1, 1'b1);
        step("stkclr");
        set_all(1'b0, 64'd0, 1'b1);
        repeat (8) step("stkclr");
        set_all(1'b0, 64'd0, 1'b1);
        step("clr");
        idle(2);

        repeat (1500) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rrst");
            end else begin
                for (int i = 0; i < N; i++) begin
                    drv_v[i] = ($urandom_range(0, 3) != 0);
                    drv_d[i] = rand_word();
                    drv_c[i] = ($urandom_range(0, 7) == 0);
                end
                step("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_gate.md
OR_GATE -- requirements
Module: or_gate

Interface
REQ-001 Parameter WIDTH, default 3, number of OR inputs; legal range 2..64.
REQ-002 Parameter PIPELINE, default 0; 0 = single output register, 1 = register after every 2-input tree level.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset; the block has one clock and the reset is asynchronous and active-low.
REQ-005 in_valid  input  1  in_data qualifier.
REQ-006 in_data  input  WIDTH  operand bits; bit 0 is the LSB.
REQ-007 out_comb  output  1  combinational OR of all in_data bits, independent of in_valid and clk.
REQ-008 out_valid  output  1  registered, asserted when out_q carries a result.
REQ-009 out_q  output  1  registered OR-reduction of an in_data word accepted with in_valid=1.
REQ-010 sticky  output  1  accumulated OR, present only with OR_GATE_STICKY_EN.
REQ-011 sticky_clr  input  1  synchronous sticky clear, present only with OR_GATE_STICKY_EN.

Function
REQ-012 out_comb SHALL equal 1 when any in_data bit is 1; it SHALL be 0 only when in_data is all zeros.
REQ-013 The reduction SHALL be built as a balanced tree of 2-input OR cells: level k pairs the level k-1 results; an odd leftover passes through unchanged to the next level.
REQ-014 Tree depth SHALL be D = ceil(log2(WIDTH)); for WIDTH=3, D=2.
REQ-015 PIPELINE=0: out_q and out_valid SHALL update 1 cycle after the accepting edge.
REQ-016 PIPELINE=1: latency SHALL be D cycles, and a new word SHALL be accepted every cycle, so throughput is 1 per cycle.
REQ-017 out_valid SHALL be in_valid delayed by exactly the latency; there is no backpressure.
REQ-018 When in_valid=0, out_valid SHALL be 0 at the matching output cycle, and out_q SHALL hold its previous value.
REQ-019 X-free operation: for any legal in_data, out_q SHALL be 0 or 1 and never X after reset.

Reset
REQ-020 rst_n low SHALL immediately clear out_q, out_valid, all pipeline registers and sticky to 0.
REQ-021 Reset asserted mid-pipeline SHALL discard all in-flight words; no out_valid SHALL follow for them.
REQ-022 The first word accepted after rst_n rises SHALL appear with normal latency.

Configuration
REQ-023 Macro OR_GATE_STICKY_EN: when defined, sticky and sticky_clr SHALL exist.
REQ-024 With the macro defined, on every cycle where out_valid=1, sticky SHALL be set if out_q=1.
REQ-025 With the macro defined, sticky_clr=1 SHALL clear sticky to 0 at the next edge.
REQ-026 With the macro defined, if sticky_clr and a set event occur in the same cycle, set SHALL win and sticky SHALL be 1.
REQ-027 Without the macro, sticky and sticky_clr SHALL be absent, and no sticky logic SHALL be synthesized.

Structure
REQ-028 A shared package or_gate_pkg SHALL hold the WIDTH legal limits and a constant function computing D = ceil(log2(WIDTH)).
REQ-029 The 2-input OR node SHALL be a sub-module or2_cell, with optional output register selected by a parameter; the tree SHALL be generated from it.

Verification
REQ-030 Exhaustive test, WIDTH=3, PIPELINE=0: apply in_data 000..111 with in_valid=1 → out_comb=0 only for 000, otherwise 1, and out_q matches one cycle later.
REQ-031 Pipelined test, WIDTH=3, PIPELINE=1: drive back-to-back 000,100,000,001 → out_q sequence 0,1,0,1 with out_valid high starting 2 cycles after the first word.
REQ-032 Bubble test: drive in_valid pattern 1,0,1 with data 010,111,000 → out_valid 1,0,1, out_q 1, held, 0.
REQ-033 Reset test: assert rst_n=0 while 2 words are in flight (PIPELINE=1) → outputs 0 at once; no out_valid after release until a new word is sent.
REQ-034 Sticky test (macro defined): send words 000, 010, 000 → sticky 0,1,1; sticky_clr together with a valid 1 → sticky stays 1; a clear alone → 0.
REQ-035 Width test, WIDTH=64: a single 1 in bit 63 only → out_q=1; all zeros → out_q=0.
